// File: rtl/bcd_to_bin_seq_if.sv
// Valid/ready handshake bundle for the sequential BCD-to-binary converter.
// The master side feeds BCD words and consumes results; the slave side is the converter.
interface bcd_to_bin_seq_if #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: multiply-accumulate, one digit per clock,
// most significant digit first, valid/ready on both sides.
// Optional build macro BCD2BIN_CLAMP_EN: nibbles above 9 are accumulated as 9.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input logic             clk,
  input logic             rst,
  bcd_to_bin_seq_if.slave bus
);

  localparam int unsigned SrW  = 4 * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [SrW-1:0]    sr_q, sr_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              err_l_q, err_l_d;

  logic              err_in;
  logic [3:0]        digit_raw;
  logic [3:0]        digit;
  logic [BIN_W+3:0]  acc_ext;
  logic [BIN_W+3:0]  mac;
  logic [BIN_W-1:0]  acc_next;

  // Flag any non-decimal nibble in the incoming word.
  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) err_in = 1'b1;
    end
  end

  // acc*10 + digit as shift-and-add, widened by 4 bits before truncation.
  always_comb begin
    digit_raw = sr_q[SrW-1 -: 4];
`ifdef BCD2BIN_CLAMP_EN
    digit     = (digit_raw > 4'd9) ? 4'd9 : digit_raw;
`else
    digit     = digit_raw;
`endif
    acc_ext   = {4'b0000, acc_q};
    mac       = (acc_ext << 3) + (acc_ext << 1) + {{BIN_W{1'b0}}, digit};
    acc_next  = mac[BIN_W-1:0];
  end

  // Next-state and datapath updates for the IDLE/CONV/DONE sequence.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    err_l_d = err_l_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sr_d    = bus.bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          err_l_d = err_in;
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d = acc_next;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DIGITS - 1)) begin
          bin_d   = acc_next;
          err_d   = err_l_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      err_l_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      err_l_q <= err_l_d;
    end
  end

  // Handshake outputs come straight from registered state.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.bin_out   = bin_q;
  assign bus.err       = err_q;

endmodule
